cm3_reset_ctrl: RTL and testbench
=================================

Name: cm3_reset_ctrl

Overview:
- Reset sequencer for the CM3 minimal SoC. Sits between the board pushbutton/PLL-lock and the SoC.
- Qualifies PLL lock, then releases power-on reset (PORESETn) and system reset (SYSRESETn) in a fixed order with programmable hold times.
- Services core-requested warm resets (SYSRESETREQ) without disturbing the debug domain. Reports the last reset cause.

Parameters:
- POR_CYCLES, 255, PORESETn low time in CLK cycles after lock is qualified (>=1).
- SYS_CYCLES, 16, SYSRESETn low time after PORESETn release, and warm-reset pulse width (>=1).
- SYNC_STAGES, 2, flop stages on PLL_LOCKED synchronizer (>=2).

Ports:
- CLK  input  1  system clock (hclk from PLL).
- RESET  input  1  synchronous, active-high reset (pushbutton, already in CLK domain).
- PLL_LOCKED  input  1  PLL lock, asynchronous; synchronized internally.
- SYSRESETREQ  input  1  warm-reset request from core, level, CLK domain.
- LOCKUP  input  1  core lockup indication, CLK domain (used only with the optional feature).
- PORESETn  output  1  power-on reset to SoC/debug, active-low, registered.
- SYSRESETn  output  1  system reset to core/bus, active-low, registered.
- RST_CAUSE  output  2  cause of last reset: 00 button, 01 PLL loss, 10 SYSRESETREQ, 11 lockup.
- RST_BUSY  output  1  high whenever state != RUN.

Behaviour:
- One clock (CLK). RESET is synchronous and active-high.
- On RESET=1 at a CLK edge:
  - state <= HOLD.
  - PORESETn=0, SYSRESETn=0, RST_CAUSE=00, RST_BUSY=1.
  - Counter cleared; synchronizer flops cleared to 0.
- All outputs are registered. PORESETn and SYSRESETn are never both released while PLL lock is unqualified.
- lock_s is the output of the SYNC_STAGES synchronizer. Latency from PLL_LOCKED change to lock_s is SYNC_STAGES cycles.
- State machine:
  - HOLD: PORESETn=0, SYSRESETn=0. On RESET=0 and lock_s=1: go to POR_WAIT, cnt <= POR_CYCLES-1.
  - POR_WAIT: PORESETn=0, SYSRESETn=0. Decrement cnt. On cnt==0: go to SYS_WAIT, cnt <= SYS_CYCLES-1, PORESETn <= 1. POR_WAIT therefore lasts exactly POR_CYCLES cycles.
  - SYS_WAIT: PORESETn=1, SYSRESETn=0. Decrement cnt. On cnt==0: go to RUN, SYSRESETn <= 1.
  - RUN: both released, RST_BUSY=0. On SYSRESETREQ=1: go to SYS_REQ, cnt <= SYS_CYCLES-1, SYSRESETn <= 0, RST_CAUSE <= 10. PORESETn stays 1.
  - SYS_REQ: SYSRESETn=0 for exactly SYS_CYCLES cycles, then go to RUN. If SYSRESETREQ is still high on return, the pulse retriggers; requests are level-sensitive.
- Priority, highest first: RESET > lock loss > LOCKUP (when enabled) > SYSRESETREQ.
- lock_s=0 in any state other than HOLD: next state HOLD, both resets asserted next edge, RST_CAUSE <= 01.
- SYSRESETREQ is ignored in HOLD, POR_WAIT and SYS_WAIT.
- RESET asserted together with SYSRESETREQ or lock loss: RST_CAUSE=00.
- Counter width is CNT_W = $clog2(max(POR_CYCLES,SYS_CYCLES)+1). No wrap: the counter is only loaded on state entry and only decremented while nonzero.
- RST_CAUSE holds its value until the next reset event.

Optional Feature:
- Macro: CM3_RESET_LOCKUP_EN.
- Defined: LOCKUP=1 in RUN behaves like SYSRESETREQ (enters SYS_REQ) but sets RST_CAUSE <= 11. If LOCKUP and SYSRESETREQ are asserted in the same cycle, cause is 11.
- Undefined: the LOCKUP port remains but is ignored. RST_CAUSE never reports 11.

Decomposition:
- Package cm3_reset_pkg:
  - rst_state_t enum: HOLD, POR_WAIT, SYS_WAIT, RUN, SYS_REQ.
  - rst_cause_t enum: CAUSE_BTN, CAUSE_PLL, CAUSE_SYSREQ, CAUSE_LOCKUP.
- Sub-module cdc_sync_bit: parameterized SYNC_STAGES-deep single-bit synchronizer with synchronous clear. It is reusable for later GPIO input sync.

Test Plan:
- Power-up: RESET=1 for 4 cycles, then RESET=0 with PLL_LOCKED=1 (POR_CYCLES=8, SYS_CYCLES=4). Expect PORESETn rising exactly SYNC_STAGES+8 cycles after RESET falls and SYSRESETn rising 4 cycles later. RST_CAUSE=00; RST_BUSY falls with SYSRESETn.
- Warm reset: in RUN, pulse SYSRESETREQ for 1 cycle. Expect SYSRESETn=0 for exactly 4 cycles, PORESETn held 1, RST_CAUSE=10, then RUN. Hold SYSRESETREQ for 10 cycles: expect back-to-back retriggered pulses.
- PLL loss: drop PLL_LOCKED in RUN. Both resets go low SYNC_STAGES+1 cycles later and RST_CAUSE=01. Restoring lock replays the full 8+4 sequence.
- Mid-sequence reset: assert RESET at POR_WAIT cnt=3. Expect HOLD next cycle and the counter restarting from 7 after release. Assert RESET simultaneously with SYSRESETREQ: expect RST_CAUSE=00.
- Ignored request: SYSRESETREQ=1 during SYS_WAIT. Expect no extension of the SYS_WAIT period and a SYS_REQ entry only once RUN is reached.
- CM3_RESET_LOCKUP_EN defined: LOCKUP=1 in RUN gives a 4-cycle SYSRESETn pulse with RST_CAUSE=11. Undefined: LOCKUP has no effect on any output.

Source files
------------

// File: rtl/cm3_reset_pkg.sv
// Shared types and helpers for the CM3 reset sequencer.
package cm3_reset_pkg;

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        POR_WAIT = 3'd1,
        SYS_WAIT = 3'd2,
        RUN      = 3'd3,
        SYS_REQ  = 3'd4
    } rst_state_t;

    typedef enum logic [1:0] {
        CAUSE_BTN    = 2'b00,
        CAUSE_PLL    = 2'b01,
        CAUSE_SYSREQ = 2'b10,
        CAUSE_LOCKUP = 2'b11
    } rst_cause_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cm3_reset_ctrl_cdc_sync_bit.sv
// Multi-stage single-bit synchronizer with synchronous clear, reusable for
// any asynchronous level input (PLL lock, GPIO).
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift chain; clear drops every stage to the unlocked/inactive level.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cm3_reset_ctrl.sv
// CM3 reset sequencer: qualifies PLL lock, releases PORESETn then SYSRESETn,
// and services warm resets. Optional lockup reset: CM3_RESET_LOCKUP_EN.
module cm3_reset_ctrl
    import cm3_reset_pkg::*;
#(
    parameter int POR_CYCLES  = 255,
    parameter int SYS_CYCLES  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PLL_LOCKED,
    input  logic       SYSRESETREQ,
    input  logic       LOCKUP,
    output logic       PORESETn,
    output logic       SYSRESETn,
    output logic [1:0] RST_CAUSE,
    output logic       RST_BUSY
);

    localparam int CNT_W = $clog2(max_int(POR_CYCLES, SYS_CYCLES) + 1);

    localparam logic [2:0] S_HOLD     = HOLD;
    localparam logic [2:0] S_POR_WAIT = POR_WAIT;
    localparam logic [2:0] S_SYS_WAIT = SYS_WAIT;
    localparam logic [2:0] S_RUN      = RUN;
    localparam logic [2:0] S_SYS_REQ  = SYS_REQ;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic             por_q, por_d;
    logic             sys_q, sys_d;
    logic             busy_q, busy_d;
    logic             lock_s;
    logic             warm_req_s;
    logic [1:0]       warm_cause_s;

    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i (CLK),
        .clr_i (RESET),
        .d_i   (PLL_LOCKED),
        .q_o   (lock_s)
    );

`ifdef CM3_RESET_LOCKUP_EN
    // Lockup wins the cause encoding when it coincides with a core request.
    always_comb begin
        warm_req_s   = SYSRESETREQ | LOCKUP;
        warm_cause_s = LOCKUP ? CAUSE_LOCKUP : CAUSE_SYSREQ;
    end
`else
    logic lockup_unused_s;
    assign lockup_unused_s = LOCKUP;

    // Only the core request can trigger a warm reset.
    always_comb begin
        warm_req_s   = SYSRESETREQ;
        warm_cause_s = CAUSE_SYSREQ;
    end
`endif

    // Sequencer next-state; lock loss outranks every in-sequence transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        if (!lock_s && (state_q != S_HOLD)) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            cause_d = CAUSE_PLL;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (lock_s) begin
                        state_d = S_POR_WAIT;
                        cnt_d   = CNT_W'(POR_CYCLES - 1);
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                S_POR_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = S_SYS_WAIT;
                        cnt_d   = CNT_W'(SYS_CYCLES - 1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_SYS_WAIT, S_SYS_REQ: begin
                    if (cnt_q == '0) begin
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (warm_req_s) begin
                        state_d = S_SYS_REQ;
                        cnt_d   = CNT_W'(SYS_CYCLES - 1);
                        cause_d = warm_cause_s;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they flip on the same edge.
    always_comb begin
        por_d  = (state_d == S_SYS_WAIT) || (state_d == S_RUN) || (state_d == S_SYS_REQ);
        sys_d  = (state_d == S_RUN);
        busy_d = (state_d != S_RUN);
    end

    // State, counter and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            cause_q <= CAUSE_BTN;
            por_q   <= 1'b0;
            sys_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            por_q   <= por_d;
            sys_q   <= sys_d;
            busy_q  <= busy_d;
        end
    end

    assign PORESETn  = por_q;
    assign SYSRESETn = sys_q;
    assign RST_CAUSE = cause_q;
    assign RST_BUSY  = busy_q;

endmodule

// File: tb/tb_cm3_reset_ctrl.sv
// Self-checking bench for cm3_reset_ctrl against an elapsed-time reference model.
module tb_cm3_reset_ctrl;

    localparam int POR = 8;
    localparam int SYS = 4;
    localparam int SS  = 2;
`ifdef CM3_RESET_LOCKUP_EN
    localparam bit LK_EN = 1'b1;
`else
    localparam bit LK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b1;
    logic       req = 1'b0;
    logic       lockup = 1'b0;
    logic       PORESETn, SYSRESETn, RST_BUSY;
    logic [1:0] RST_CAUSE;
    logic [4:0] dut_v;

    int checks = 0;
    int errors = 0;

    // Reference model: m_seq = cycles since lock was qualified (-1 = held),
    // m_warm = remaining warm-reset pulse cycles, m_hist = lock pipeline.
    int         m_seq = -1;
    int         m_warm = 0;
    logic [1:0] m_cause = 2'b00;
    bit         m_hist [SS];

    always #5 clk = ~clk;

    cm3_reset_ctrl #(
        .POR_CYCLES  (POR),
        .SYS_CYCLES  (SYS),
        .SYNC_STAGES (SS)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .PLL_LOCKED  (lock),
        .SYSRESETREQ (req),
        .LOCKUP      (lockup),
        .PORESETn    (PORESETn),
        .SYSRESETn   (SYSRESETn),
        .RST_CAUSE   (RST_CAUSE),
        .RST_BUSY    (RST_BUSY)
    );

    assign dut_v = {PORESETn, SYSRESETn, RST_CAUSE, RST_BUSY};

    function automatic logic [4:0] exp_vec();
        logic p, s;
        p = (m_seq >= POR);
        s = (m_seq >= POR + SYS) && (m_warm == 0);
        return {p, s, m_cause, ~s};
    endfunction

    function automatic bit m_run();
        return (m_seq >= POR + SYS) && (m_warm == 0);
    endfunction

    task automatic tick();
        bit ls;
        @(posedge clk);
        ls = m_hist[SS-1];
        if (rst) begin
            m_seq = -1;
            m_warm = 0;
            m_cause = 2'b00;
            for (int i = 0; i < SS; i++) m_hist[i] = 1'b0;
        end else begin
            if (m_seq < 0) begin
                if (ls) m_seq = 0;
            end else if (!ls) begin
                m_seq = -1;
                m_warm = 0;
                m_cause = 2'b01;
            end else if (m_warm > 0) begin
                m_warm--;
            end else if (m_seq < POR + SYS) begin
                m_seq++;
            end else if (req || (LK_EN && lockup)) begin
                m_warm = SYS;
                m_cause = (LK_EN && lockup) ? 2'b11 : 2'b10;
            end
            for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = lock;
        end
        #1;
    endtask

    task automatic wait_run();
        for (int n = 0; n < 40 && !m_run(); n++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; lock = 1'b1; req = 1'b0; lockup = 1'b0;
        repeat (4) begin
            tick();
            checks++;
            if (dut_v !== 5'b00001) begin
                errors++;
                $display("FAIL reset_state got %b exp %b", dut_v, 5'b00001);
            end
        end
    endtask

    task automatic test_power_up();
        int por_at = -1;
        int sys_at = -1;
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            checks++;
            if (dut_v !== exp_vec()) begin
                errors++;
                $display("FAIL power_up k=%0d got %b exp %b", k, dut_v, exp_vec());
            end
            if (PORESETn === 1'b1 && por_at < 0) por_at = k;
            if (SYSRESETn === 1'b1 && sys_at < 0) sys_at = k;
        end
        checks++;
        if (por_at != SS + POR) begin
            errors++;
            $display("FAIL power_up_por_time got %0d exp %0d", por_at, SS + POR);
        end
        checks++;
        if (sys_at != SS + POR + SYS) begin
            errors++;
            $display("FAIL power_up_sys_time got %0d exp %0d", sys_at, SS + POR + SYS);
        end
        checks++;
        if ({RST_CAUSE, RST_BUSY} !== 3'b000) begin
            errors++;
            $display("FAIL power_up_cause_busy got %b exp %b", {RST_CAUSE, RST_BUSY}, 3'b000);
        end
    endtask

    task automatic test_warm_reset();
        int lows = 0;
        int falls = 0;
        logic prev;
        req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            req = 1'b0;
            checks++;
            if (dut_v !== exp_vec() || PORESETn !== 1'b1) begin
                errors++;
                $display("FAIL warm_pulse k=%0d got %b exp %b", k, dut_v, exp_vec());
            end
            if (SYSRESETn === 1'b0) lows++;
        end
        checks++;
        if (lows != SYS || RST_CAUSE !== 2'b10) begin
            errors++;
            $display("FAIL warm_width got lows=%0d cause=%b exp lows=%0d cause=10", lows, RST_CAUSE, SYS);
        end
        req = 1'b1;
        prev = SYSRESETn;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (dut_v !== exp_vec()) begin
                errors++;
                $display("FAIL warm_hold k=%0d got %b exp %b", k, dut_v, exp_vec());
            end
            if (prev === 1'b1 && SYSRESETn === 1'b0) falls++;
            prev = SYSRESETn;
        end
        req = 1'b0;
        checks++;
        if (falls != 10 / (SYS + 1)) begin
            errors++;
            $display("FAIL warm_retrigger got %0d pulses exp %0d", falls, 10 / (SYS + 1));
        end
        wait_run();
    endtask

    task automatic test_pll_loss();
        int lo_at = -1;
        int por_at = -1;
        int sys_at = -1;
        lock = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (dut_v !== exp_vec()) begin
                errors++;
                $display("FAIL pll_loss k=%0d got %b exp %b", k, dut_v, exp_vec());
            end
            if (PORESETn === 1'b0 && SYSRESETn === 1'b0 && lo_at < 0) lo_at = k;
        end
        checks++;
        if (lo_at != SS + 1 || RST_CAUSE !== 2'b01) begin
            errors++;
            $display("FAIL pll_loss_time got %0d cause=%b exp %0d cause=01", lo_at, RST_CAUSE, SS + 1);
        end
        lock = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (PORESETn === 1'b1 && por_at < 0) por_at = k;
            if (SYSRESETn === 1'b1 && sys_at < 0) sys_at = k;
        end
        checks++;
        if (por_at != SS + 1 + POR || sys_at - por_at != SYS) begin
            errors++;
            $display("FAIL pll_relock got por=%0d sys=%0d exp por=%0d sys=%0d",
                     por_at, sys_at, SS + 1 + POR, SS + 1 + POR + SYS);
        end
    endtask

    task automatic test_mid_reset();
        int por_at = -1;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (dut_v !== 5'b00001) begin
            errors++;
            $display("FAIL mid_reset_hold got %b exp %b", dut_v, 5'b00001);
        end
        for (int k = 0; k < 16; k++) begin
            tick();
            if (PORESETn === 1'b1 && por_at < 0) por_at = k;
        end
        checks++;
        if (por_at != SS + POR) begin
            errors++;
            $display("FAIL mid_reset_restart got %0d exp %0d", por_at, SS + POR);
        end
        wait_run();
        req = 1'b1; tick(); req = 1'b0;
        wait_run();
        rst = 1'b1; req = 1'b1; tick(); rst = 1'b0; req = 1'b0;
        checks++;
        if (dut_v !== 5'b00001) begin
            errors++;
            $display("FAIL reset_with_req got %b exp %b", dut_v, 5'b00001);
        end
        wait_run();
    endtask

    task automatic test_ignored_req();
        int sys_at = -1;
        logic s15 = 1'b1;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            req = (k >= 11 && k <= 15);
            tick();
            checks++;
            if (dut_v !== exp_vec()) begin
                errors++;
                $display("FAIL ignored_req k=%0d got %b exp %b", k, dut_v, exp_vec());
            end
            if (SYSRESETn === 1'b1 && sys_at < 0) sys_at = k;
            if (k == 15) s15 = SYSRESETn;
        end
        req = 1'b0;
        checks++;
        if (sys_at != SS + POR + SYS || s15 !== 1'b0) begin
            errors++;
            $display("FAIL ignored_req_timing got sys=%0d k15=%b exp sys=%0d k15=0", sys_at, s15, SS + POR + SYS);
        end
        wait_run();
    endtask

    task automatic test_lockup();
        int lows = 0;
        lockup = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            lockup = 1'b0;
            checks++;
            if (dut_v !== exp_vec()) begin
                errors++;
                $display("FAIL lockup k=%0d got %b exp %b", k, dut_v, exp_vec());
            end
            if (SYSRESETn === 1'b0) lows++;
        end
        checks++;
        if (lows != (LK_EN ? SYS : 0) || (RST_CAUSE === 2'b11) != LK_EN) begin
            errors++;
            $display("FAIL lockup_effect got lows=%0d cause=%b exp lows=%0d", lows, RST_CAUSE, LK_EN ? SYS : 0);
        end
        wait_run();
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            rst    = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 59) == 0) lock = ~lock;
            if (!lock && $urandom_range(0, 3) == 0) lock = 1'b1;
            req    = ($urandom_range(0, 9) == 0);
            lockup = ($urandom_range(0, 11) == 0);
            tick();
            checks++;
            if (dut_v !== exp_vec()) begin
                errors++;
                $display("FAIL random k=%0d got %b exp %b", k, dut_v, exp_vec());
            end
        end
        rst = 1'b0; lock = 1'b1; req = 1'b0; lockup = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_warm_reset();
        test_pll_loss();
        test_mid_reset();
        test_ignored_req();
        test_lockup();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
